// File: rtl/led_pattern_gen.sv
// LED pattern generator: N LEDs, loadable step period, four pattern modes,
// enable gating and PWM brightness on registered outputs.
module led_pattern_gen #(
    parameter int          NUM_LEDS       = 4,
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 49_999_999,
    parameter int          PWM_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    period,
    input  logic [PWM_W-1:0]    brightness,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_tick
);

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam logic [CNT_W-1:0]    DEF_P   = CNT_W'(DEFAULT_PERIOD);
    localparam logic [NUM_LEDS-1:0] PAT_LSB = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] PAT_MSB = PAT_LSB << (NUM_LEDS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    period_q;
    logic [1:0]          mode_q;
    logic [NUM_LEDS-1:0] pattern;
    logic [NUM_LEDS-1:0] pattern_nxt;
    logic [NUM_LEDS-1:0] start_pat;
    dir_t                dir;
    dir_t                dir_nxt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                tick;
    logic                pwm_on;

    assign tick   = en & (cnt >= period_q);
    assign pwm_on = (pwm_cnt < brightness) | (&brightness);

    always_comb begin
        unique case (mode)
            2'd1:    start_pat = PAT_MSB;
            2'd3:    start_pat = '1;
            default: start_pat = PAT_LSB;
        endcase
    end

    always_comb begin
        pattern_nxt = pattern;
        dir_nxt     = dir;
        if (load) begin
            pattern_nxt = start_pat;
            dir_nxt     = DIR_LEFT;
        end else if (tick) begin
            unique case (mode_q)
                2'd0: pattern_nxt = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
                2'd1: pattern_nxt = {pattern[0], pattern[NUM_LEDS-1:1]};
                2'd2: begin
                    // Reverse at either end so the lit LED never leaves the bar.
                    if (dir == DIR_LEFT) begin
                        if (pattern[NUM_LEDS-1]) begin
                            dir_nxt     = DIR_RIGHT;
                            pattern_nxt = pattern >> 1;
                        end else begin
                            pattern_nxt = pattern << 1;
                        end
                    end else begin
                        if (pattern[0]) begin
                            dir_nxt     = DIR_LEFT;
                            pattern_nxt = pattern << 1;
                        end else begin
                            pattern_nxt = pattern >> 1;
                        end
                    end
                end
                default: pattern_nxt = ~pattern;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            period_q  <= DEF_P;
            mode_q    <= 2'd0;
            pattern   <= PAT_LSB;
            dir       <= DIR_LEFT;
            pwm_cnt   <= '0;
            led       <= '0;
            step_tick <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
            step_tick <= tick & ~load;
            led       <= pwm_on ? pattern : '0;
            pattern   <= pattern_nxt;
            dir       <= dir_nxt;
            if (load) begin
                mode_q   <= mode;
                period_q <= period;
                cnt      <= '0;
            end else if (en) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule
